// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline. It sits between EX and WB.
// It latches the EX->MEM bus and completes the read-response handshake for loads.
// Load data is byte/half-selected and extended. Results are forwarded to WB and to ID.
module mem_stage #(
   parameter int EX_TO_MEM_BUS_WD = 108,
   parameter int MEM_TO_WB_BUS_WD = 70,
   parameter int RDW_BUS_WD       = 39
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        WB_Allow_in,
   output logic                        MEM_Allow_in,
   input  logic                        EX_to_MEM_Valid,
   input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_Bus,
   input  logic [31:0]                 Read_data,
   input  logic                        Read_data_Valid,
   output logic                        Read_data_Ready,
   output logic                        MEM_to_WB_Valid,
   output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_Bus,
   output logic [RDW_BUS_WD-1:0]       rdw_MEM_Bus,
   output logic                        Mem_Feedback
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_WAIT_RD = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] ld_data_q;
   // Only the low 76 bits are needed past EX; rdata2 was consumed by the store in EX.
   logic [75:0] bus_q;

   logic        mem_ready;
   logic        rd_fire;
   logic        accept;
   logic [31:0] result;
   logic [2:0]  funct3;
   logic        is_load;
   logic        wb_wen;
   logic [4:0]  waddr;
   logic [31:0] pc;
   logic [31:0] wb_data;
   logic        wb_wen_out;
   logic        data_ok;
   logic        unused_bits;

   // Byte/half select from a word-aligned read, then sign or zero extend.
   function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (f3)
         3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
         3'b100:  load_ext = {24'd0, sh[7:0]};
         3'b101:  load_ext = {16'd0, sh[15:0]};
         default: load_ext = w;
      endcase
   endfunction

   assign result  = bus_q[75:44];
   assign funct3  = bus_q[43:41];
   assign is_load = bus_q[40];
   assign wb_wen  = bus_q[37];
   assign waddr   = bus_q[36:32];
   assign pc      = bus_q[31:0];

   // STORE and MEM_wen were acted on in EX; rdata2 likewise.
   assign unused_bits = ^{EX_to_MEM_Bus[107:76], bus_q[39:38]};

   assign mem_ready       = (state_q == S_HOLD);
   assign rd_fire         = (state_q == S_WAIT_RD) & Read_data_Valid;
   assign MEM_Allow_in    = ~mem_valid_q | (mem_ready & WB_Allow_in);
   assign accept          = EX_to_MEM_Valid & MEM_Allow_in;
   assign Read_data_Ready = (state_q == S_WAIT_RD);
   assign Mem_Feedback    = ~(state_q == S_WAIT_RD);
   assign MEM_to_WB_Valid = mem_valid_q & mem_ready;

   assign wb_data    = is_load ? load_ext(funct3, result[1:0], ld_data_q) : result;
   assign wb_wen_out = wb_wen & mem_valid_q;
   assign data_ok    = ~is_load | (state_q == S_HOLD);

   assign MEM_to_WB_Bus = {wb_wen_out, waddr, wb_data, pc};
   assign rdw_MEM_Bus   = {data_ok, wb_wen_out, waddr, wb_data};

   // Next state: entry (including back-to-back) wins; otherwise a read handshake moves WAIT_RD to HOLD.
   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      if (MEM_Allow_in) begin
         mem_valid_d = EX_to_MEM_Valid;
         if (EX_to_MEM_Valid) begin
            state_d = EX_to_MEM_Bus[40] ? S_WAIT_RD : S_HOLD;
         end else begin
            state_d = S_EMPTY;
         end
      end else if (rd_fire) begin
         state_d = S_HOLD;
      end
   end

   // Control state and captured load data; reset drops any outstanding load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         mem_valid_q <= 1'b0;
         ld_data_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         if (rd_fire) begin
            ld_data_q <= Read_data;
         end
      end
   end

   // EX->MEM pipeline register; data only, qualified by mem_valid_q.
   always_ff @(posedge clk) begin
      if (accept) begin
         bus_q <= EX_to_MEM_Bus[75:0];
      end
   end

endmodule
